// File: rtl/sb_pkg.sv
// Shared sideband definitions used by the transmit serializer and the receiver.
package sb_pkg;

  localparam int unsigned SB_WORD_W  = 64;
  localparam int unsigned SB_IDLE_UI = 32;

  typedef enum logic [1:0] {
    SB_TX_IDLE,
    SB_TX_SEND,
    SB_TX_GAP
  } sb_tx_state_t;

endpackage

// File: rtl/sb_fifo.sv
// Synchronous word FIFO with occupancy count; shared by sideband TX and RX paths.
module sb_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop_i) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/sb_tx_serializer.sv
// Sideband transmit serializer: buffers 64-bit words and shifts them LSB-first onto
// the data pin with a forwarded clock (1 UI = 2 clk), followed by a fixed low-data gap.
module sb_tx_serializer
  import sb_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 4,
  parameter int unsigned IDLE_UI     = SB_IDLE_UI
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SB_WORD_W-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 dataPin_o,
  output logic                 clkPin_o,
  output logic                 busy_o
);

  localparam int unsigned CW = $clog2(BUFFER_SIZE) + 1;
  localparam int unsigned GW = $clog2(IDLE_UI) + 1;

  sb_tx_state_t         r_state, w_state_d;
  logic [SB_WORD_W-1:0] r_shift, w_shift_d;
  logic [5:0]           r_bit_cnt, w_bit_cnt_d;
  logic [GW-1:0]        r_gap_cnt, w_gap_cnt_d;
  logic                 r_phase, w_phase_d;
  logic                 r_clk_pin, w_clk_pin_d;
  logic                 r_data_pin, w_data_pin_d;

  logic                 w_push;
  logic                 w_pop;
  logic [SB_WORD_W-1:0] w_fifo_data;
  logic [CW-1:0]        w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  assign ready_o = !w_fifo_full;
  assign w_push  = valid_i && ready_o;

  sb_fifo #(
    .WIDTH (SB_WORD_W),
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (data_i),
    .data_o  (w_fifo_data),
    .count_o (w_fifo_count),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // r_phase=0 is the clock-high half of a UI; state advances at the end of phase 1.
  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_bit_cnt_d = r_bit_cnt;
    w_gap_cnt_d = r_gap_cnt;
    w_phase_d   = 1'b0;
    w_pop       = 1'b0;

    case (r_state)
      SB_TX_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_d   = w_fifo_data;
          w_bit_cnt_d = '0;
          w_state_d   = SB_TX_SEND;
        end
      end
      SB_TX_SEND: begin
        w_phase_d = ~r_phase;
        if (r_phase) begin
          if (r_bit_cnt == 6'd63) begin
            w_gap_cnt_d = '0;
            w_state_d   = SB_TX_GAP;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 6'd1;
          end
        end
      end
      SB_TX_GAP: begin
        w_phase_d = ~r_phase;
        if (r_phase) begin
          if (r_gap_cnt == GW'(IDLE_UI - 1)) begin
            if (!w_fifo_empty) begin
              w_pop       = 1'b1;
              w_shift_d   = w_fifo_data;
              w_bit_cnt_d = '0;
              w_state_d   = SB_TX_SEND;
            end else begin
              w_state_d = SB_TX_IDLE;
            end
          end else begin
            w_gap_cnt_d = r_gap_cnt + 1'b1;
          end
        end
      end
      default: w_state_d = SB_TX_IDLE;
    endcase

    // Pins are registered one cycle behind the state so they change only on clkPin_o rise.
    w_clk_pin_d  = (r_state != SB_TX_IDLE) && !r_phase;
    w_data_pin_d = (r_state == SB_TX_SEND) && r_shift[r_bit_cnt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= SB_TX_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_phase    <= 1'b0;
      r_clk_pin  <= 1'b0;
      r_data_pin <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_shift    <= w_shift_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_gap_cnt  <= w_gap_cnt_d;
      r_phase    <= w_phase_d;
      r_clk_pin  <= w_clk_pin_d;
      r_data_pin <= w_data_pin_d;
    end
  end

  assign clkPin_o  = r_clk_pin;
  assign dataPin_o = r_data_pin;
  assign busy_o    = (r_state != SB_TX_IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed bench for sb_tx_serializer with a pin trace and a falling-edge receiver model.
module tb_sb_tx_serializer;

  localparam int LOG_N = 32768;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] data = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        dpin;
  logic        cpin;
  logic        busy;

  sb_tx_serializer #(
    .BUFFER_SIZE (4),
    .IDLE_UI     (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_i    (data),
    .valid_i   (valid),
    .ready_o   (ready),
    .dataPin_o (dpin),
    .clkPin_o  (cpin),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // trace[c] = {busy, clkPin, dataPin} during the cycle following rising edge c
  logic [2:0] trace [LOG_N];
  always @(negedge clk) if (cyc < LOG_N) trace[cyc] <= {busy, cpin, dpin};

  int rises = 0;
  always @(posedge cpin) rises <= rises + 1;

  // Receiver model: 64 data UIs captured on clkPin falling edge, then IDLE_UI gap UIs skipped
  logic [6:0]  rx_ui = '0;
  logic [63:0] rx_sh = '0;
  logic [63:0] rx_q [$];
  logic [63:0] exp_q [$];
  always @(negedge cpin or posedge reset) begin
    if (reset) begin
      rx_ui <= '0;
    end else begin
      if (rx_ui < 7'd64) rx_sh[rx_ui[5:0]] <= dpin;
      if (rx_ui == 7'd63) rx_q.push_back({dpin, rx_sh[62:0]});
      rx_ui <= (rx_ui == 7'd95) ? 7'd0 : rx_ui + 7'd1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds valid until accepted and returns the accepting edge index.
  task automatic push_word(input logic [63:0] w, output int n);
    n = -1;
    data  = w;
    valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (ready) begin
        n = cyc + 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check_eq("push_accepted", 64'(n >= 0), 64'd1);
    if (n >= 0) exp_q.push_back(w);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int t = 0; t < budget; t++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check_eq(tag, 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_packet(input int n, input logic [63:0] w, input string tag);
    logic [63:0] got;
    int bad;
    bad = 0;
    got = '0;
    for (int k = 0; k < 64; k++) begin
      got[k] = trace[n + 2 + 2 * k][0];
      if (trace[n + 3 + 2 * k][0] !== trace[n + 2 + 2 * k][0]) bad++;
      if (trace[n + 2 + 2 * k][1] !== 1'b1 || trace[n + 3 + 2 * k][1] !== 1'b0) bad++;
    end
    check_eq({tag, "_bits"}, got, w);
    check_eq({tag, "_ui_shape"}, 64'(bad), 64'd0);
  endtask

  task automatic check_gap(input int n, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (trace[n + 130 + k][0] !== 1'b0) bad++;
      if (trace[n + 130 + k][1] !== ((k % 2) == 0)) bad++;
    end
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) check_eq(tag, rx_q[i], exp_q[i]);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n2, n3, m, r0;
    int na [5];

    repeat (3) @(negedge clk);
    check_eq("rst_clkpin", 64'(cpin), 64'd0);
    check_eq("rst_datapin", 64'(dpin), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 64'(ready), 64'd1);

    // Single word: bit order, first clock rise, full gap, then static low.
    push_word(64'h0123_4567_89AB_CDEF, n);
    valid = 1'b0;
    wait_idle("t1_idle", 400);
    check_eq("t1_no_early_clk", 64'(trace[n + 1][1]), 64'd0);
    check_eq("t1_first_rise", 64'(trace[n + 2][1]), 64'd1);
    check_packet(n, 64'h0123_4567_89AB_CDEF, "t1");
    check_gap(n, "t1_gap");
    check_eq("t1_after_gap", 64'(trace[n + 194]), 64'd0);
    check_rx("t1_rx");

    // Three words back-to-back.
    push_word({8{8'hA5}}, n1);
    push_word({64{1'b1}}, n2);
    push_word(64'h0, n3);
    valid = 1'b0;
    check_eq("t2_consecutive", 64'(n3 - n1), 64'd2);
    wait_idle("t2_idle", 800);
    check_packet(n1, {8{8'hA5}}, "t2_w0");
    check_packet(n1 + 192, {64{1'b1}}, "t2_w1");
    check_packet(n1 + 384, 64'h0, "t2_w2");
    check_gap(n1, "t2_gap0");
    check_gap(n1 + 192, "t2_gap1");
    check_gap(n1 + 384, "t2_gap2");
    check_rx("t2_rx");

    // Five pushes in consecutive cycles: early pop keeps all five flowing.
    for (int i = 0; i < 5; i++) push_word({8{8'h10 + 8'(i)}}, na[i]);
    check_eq("t3_ready_full", 64'(ready), 64'd0);
    valid = 1'b0;
    check_eq("t3_consecutive", 64'(na[4] - na[0]), 64'd4);
    wait_idle("t3_idle", 1200);
    check_rx("t3_rx");

    // Reset mid-packet at bit 20 with two words queued.
    push_word({64{1'b1}}, n);
    push_word(64'h1, m);
    push_word(64'h2, m);
    valid = 1'b0;
    while (cyc < n + 42) @(negedge clk);
    check_eq("t4_bit20", 64'({cpin, dpin}), 64'd3);
    reset = 1'b1;
    #1;
    check_eq("t4_rst_pins", 64'({cpin, dpin}), 64'd0);
    r0 = rises;
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("t4_no_edges", 64'(rises), 64'(r0));
    check_eq("t4_ready", 64'(ready), 64'd1);
    check_eq("t4_busy", 64'(busy), 64'd0);
    check_eq("t4_rx_none", 64'(rx_q.size()), 64'd0);
    rx_q.delete();
    exp_q.delete();

    // Word presented mid-gap waits for the full gap.
    push_word(64'hDEAD_BEEF_0000_0001, n);
    valid = 1'b0;
    while (cyc < n + 140) @(negedge clk);
    push_word(64'h8000_0000_CAFE_F00D, m);
    valid = 1'b0;
    check_eq("t5_accept_in_gap", 64'(m), 64'(n + 141));
    wait_idle("t5_idle", 800);
    check_gap(n, "t5_gap");
    check_packet(n + 192, 64'h8000_0000_CAFE_F00D, "t5_w1");
    check_rx("t5_rx");

    // Loopback of 100 random words through the receiver model.
    for (int i = 0; i < 100; i++) push_word({$urandom, $urandom}, n);
    valid = 1'b0;
    wait_idle("t6_idle", 100 * 200 + 400);
    check_rx("t6_rx");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
